button_event_decoder: RTL

// - Consumes the spi_dev_proto write stream (pw_*) and decodes button-report frames (command CMD).
// - Keeps the current 11-button state and turns every press/release into a 6-bit event in a FIFO.
// - Events are read out over a valid/ready handshake. Feeds menu/game logic that needs edges, not levels.

---
 rtl/button_event_decoder_if.sv | 21 ++
 rtl/button_event_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder_if.sv
// Write-stream input and event-output handshake of button_event_decoder.
// master = stream source / event consumer, slave = the decoder.
interface button_event_decoder_if;
    logic [7:0] pw_wdata;
    logic       pw_wcmd;
    logic       pw_wstb;
    logic       pw_end;
    logic       evt_valid;
    logic [5:0] evt_data;
    logic       evt_ready;

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, evt_ready,
        input  evt_valid, evt_data
    );

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, evt_ready,
        output evt_valid, evt_data
    );
endinterface

// File: rtl/button_event_decoder.sv
// Decodes button-report frames into press/release events buffered in a show-ahead FIFO.
// Optional auto-repeat of held direction buttons: define BUTTON_AUTOREPEAT_EN.
module button_event_decoder #(
    parameter logic [7:0]  CMD           = 8'hF4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned REPEAT_DELAY  = 24000000,
    parameter int unsigned REPEAT_PERIOD = 4800000
) (
    input  logic                         clk,
    input  logic                         rst,
    button_event_decoder_if.slave        bus,
    output logic [10:0]                  btn_state,
    output logic                         overflow,
    output logic                         frame_err,
    input  logic                         err_clr
);
    localparam int unsigned NBTN     = 11;
    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW       = AW + 1;
    localparam logic [3:0]  LAST_IDX = 4'(NBTN - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("button_event_decoder: invalid parameter set");
    end

    // ---------------- frame parser ----------------
    logic [7:0]  r_cmd,      w_cmd_nxt;
    logic        r_have_cmd, w_have_cmd_nxt;
    logic [2:0]  r_cnt,      w_cnt_nxt;
    logic [26:0] r_word,     w_word_nxt;
    logic        w_frame_end_cmd, w_frame_new, w_frame_bad;
    logic [10:0] w_frame_btn;

    // A strobe in the same cycle as pw_end is folded in before the frame is judged.
    always_comb begin
        w_cmd_nxt      = r_cmd;
        w_have_cmd_nxt = r_have_cmd;
        w_cnt_nxt      = r_cnt;
        w_word_nxt     = r_word;
        if (bus.pw_wstb) begin
            if (bus.pw_wcmd) begin
                w_cmd_nxt      = bus.pw_wdata;
                w_have_cmd_nxt = 1'b1;
                w_cnt_nxt      = '0;
            end else begin
                w_word_nxt = {r_word[18:0], bus.pw_wdata};
                if (r_cnt != 3'd7) w_cnt_nxt = r_cnt + 3'd1;
            end
        end
    end

    assign w_frame_end_cmd = bus.pw_end & w_have_cmd_nxt & (w_cmd_nxt == CMD);
    assign w_frame_new     = w_frame_end_cmd & (w_cnt_nxt == 3'd4);
    assign w_frame_bad     = w_frame_end_cmd & (w_cnt_nxt != 3'd4);
    assign w_frame_btn     = w_word_nxt[26:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= '0;
            r_have_cmd <= 1'b0;
            r_cnt      <= '0;
            r_word     <= '0;
        end else begin
            r_cmd      <= w_cmd_nxt;
            r_have_cmd <= w_have_cmd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_word     <= w_word_nxt;
        end
    end

    // ---------------- scanner FSM ----------------
    typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_btn, r_chg, r_pend;
    logic        r_pend_vld;
    logic [3:0]  r_idx;
    logic        w_load, w_scan_push, w_pend_set, w_pend_clr;
    logic [10:0] w_load_val;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_frame_new | r_pend_vld) w_state_nxt = S_SCAN;
            S_SCAN:  if (r_idx == LAST_IDX)        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A frame arriving in the same IDLE cycle as a pending one is newer and wins.
    always_comb begin
        w_load      = 1'b0;
        w_load_val  = w_frame_btn;
        w_scan_push = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pend_clr = 1'b1;
                if (w_frame_new) begin
                    w_load = 1'b1;
                end else if (r_pend_vld) begin
                    w_load     = 1'b1;
                    w_load_val = r_pend;
                end
            end
            S_SCAN: begin
                w_scan_push = r_chg[r_idx];
                w_pend_set  = w_frame_new;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn      <= '0;
            r_chg      <= '0;
            r_idx      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            if (w_load) begin
                r_btn <= w_load_val;
                r_chg <= w_load_val ^ r_btn;
                r_idx <= '0;
            end else if (r_state == S_SCAN) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_pend_set) begin
                r_pend_vld <= 1'b1;
                r_pend     <= w_frame_btn;
            end else if (w_pend_clr) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // ---------------- auto-repeat ----------------
    logic       w_rpt_push;
    logic [5:0] w_rpt_data;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] r_rpt_cnt, w_rpt_lim;
    logic          r_rpt_first, r_rpt_req;
    logic [3:0]    r_rpt_code, w_rpt_code;
    logic          w_rpt_restart, w_rpt_held, w_rpt_fire;

    assign w_rpt_restart = w_load & (w_load_val != r_btn);
    assign w_rpt_held    = |r_btn[3:0];
    assign w_rpt_lim     = r_rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign w_rpt_fire    = ~w_rpt_restart & w_rpt_held & (r_rpt_cnt == w_rpt_lim);
    assign w_rpt_push    = r_rpt_req & (r_state == S_IDLE) & ~w_rpt_restart;
    assign w_rpt_data    = {2'b11, r_rpt_code};

    // Lowest-index held direction button is the one that repeats.
    always_comb begin
        w_rpt_code = 4'd3;
        if (r_btn[2]) w_rpt_code = 4'd2;
        if (r_btn[1]) w_rpt_code = 4'd1;
        if (r_btn[0]) w_rpt_code = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
            r_rpt_req   <= 1'b0;
            r_rpt_code  <= '0;
        end else if (w_rpt_restart) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
            r_rpt_req   <= 1'b0;
        end else begin
            if (w_rpt_held) begin
                if (r_rpt_cnt == w_rpt_lim) begin
                    r_rpt_cnt   <= '0;
                    r_rpt_first <= 1'b0;
                end else begin
                    r_rpt_cnt <= r_rpt_cnt + RW'(1);
                end
            end
            if (w_rpt_fire) begin
                r_rpt_req  <= 1'b1;
                r_rpt_code <= w_rpt_code;
            end else if (w_rpt_push) begin
                r_rpt_req <= 1'b0;
            end
        end
    end
`else
    assign w_rpt_push = 1'b0;
    assign w_rpt_data = '0;
`endif

    // ---------------- event FIFO ----------------
    logic          w_push, w_pop, w_full, w_push_ok, w_drop;
    logic [5:0]    w_push_data;
    logic [5:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_valid;

    assign w_push      = w_scan_push | w_rpt_push;
    assign w_push_data = w_scan_push ? {1'b0, r_btn[r_idx], r_idx} : w_rpt_data;
    assign w_pop       = r_valid & bus.evt_ready;
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
    end

    // ---------------- sticky errors ----------------
    logic r_overflow, r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop)           r_overflow <= 1'b1;
            else if (err_clr)     r_overflow <= 1'b0;
            if (w_frame_bad)      r_frame_err <= 1'b1;
            else if (err_clr)     r_frame_err <= 1'b0;
        end
    end

    assign btn_state     = r_btn;
    assign overflow      = r_overflow;
    assign frame_err     = r_frame_err;
    assign bus.evt_valid = r_valid;
    assign bus.evt_data  = r_mem[r_rd_ptr];
endmodule
